// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receiver (8N1, LSB first) with a byte FIFO, framing and overrun error pulses
module uart_rx_deser #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DIV_WIDTH-1:0]          clkdiv,
  input  logic                          rx,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_framing,
  output logic                          err_overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state_q, state_d;
  logic rx_s1_q, rx_s2_q;
  logic [DIV_WIDTH-1:0] presc_q, presc_d, div_eff;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] lvl_q, lvl_d;
  logic err_framing_q, err_framing_d, err_overrun_q, err_overrun_d;
  logic tick, mid, bit_end, push, pop, full, accept;

  assign div_eff  = (clkdiv == '0) ? DIV_WIDTH'(1) : clkdiv;
  assign tick     = presc_q >= div_eff - DIV_WIDTH'(1);
  assign mid      = tick && tcnt_q == TW'(OVERSAMPLE / 2 - 1);
  assign bit_end  = tick && tcnt_q == TW'(OVERSAMPLE - 1);
  assign out_valid = lvl_q != '0;
  assign full     = lvl_q == (AW+1)'(FIFO_DEPTH);
  assign pop      = out_valid && out_ready;
  assign push     = en && state_q == STOP && bit_end && rx_s2_q;
  assign accept   = push && (!full || pop);
  assign out_data = mem_q[rd_q];
  assign fifo_level  = lvl_q;
  assign err_framing = err_framing_q;
  assign err_overrun = err_overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      presc_q       <= '0;
      tcnt_q        <= '0;
      bcnt_q        <= '0;
      sh_q          <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      lvl_q         <= '0;
      err_framing_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_s1_q       <= rx;
      rx_s2_q       <= rx_s1_q;
      presc_q       <= presc_d;
      tcnt_q        <= tcnt_d;
      bcnt_q        <= bcnt_d;
      sh_q          <= sh_d;
      mem_q         <= mem_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      lvl_q         <= lvl_d;
      err_framing_q <= err_framing_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = !rx_s2_q ? START : IDLE;
      START:     state_d = mid ? (rx_s2_q ? IDLE : DATA) : START;
      DATA:      state_d = (bit_end && bcnt_q == 3'd7) ? STOP : DATA;
      STOP:      state_d = bit_end ? (rx_s2_q ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_d = rx_s2_q ? IDLE : WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  always_comb begin
    presc_d = (state_q == IDLE || tick) ? '0 : presc_q + DIV_WIDTH'(1);
    tcnt_d = (state_q inside {IDLE, WAIT_HIGH} || (state_q == START ? mid : bit_end)) ? '0 : tcnt_q + TW'(tick);
    bcnt_d = (state_q == START) ? '0 : bcnt_q + 3'(state_q == DATA && bit_end);
    sh_d = (state_q == DATA && bit_end) ? {rx_s2_q, sh_q[7:1]} : sh_q;
    mem_d = mem_q;
    if (accept) mem_d[wr_q] = sh_q;
    wr_d = wr_q + AW'(accept);
    rd_d = rd_q + AW'(pop);
    lvl_d = lvl_q + (AW+1)'(accept) - (AW+1)'(pop);
    err_framing_d = en && state_q == STOP && bit_end && !rx_s2_q;
    err_overrun_d = push && !accept;
  end
endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning oversample ticks per bit (even, >= 4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of 2, >= 2).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, meaning width of the clock divider input.
REQ-004 SHALL have ports:
- clk  input  1  system clock; one clock domain.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  receiver enable.
- clkdiv  input  DIV_WIDTH  clk cycles per oversample tick.
- rx  input  1  asynchronous serial line, idle high.
- out_data  output  8  head-of-FIFO byte.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the byte.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- err_framing  output  1  one-cycle pulse, bad stop bit.
- err_overrun  output  1  one-cycle pulse, byte dropped because FIFO full.

Function
REQ-005 SHALL pass rx through a 2-flop synchroniser; all logic uses the synchronised value only.
REQ-006 SHALL generate an oversample tick every max(clkdiv,1) clk cycles; clkdiv=0 behaves as 1.
REQ-007 SHALL clear the prescaler on entry to START so the first tick falls clkdiv cycles after the detected falling edge.
REQ-008 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-009 IDLE: synchronised rx=0 with en=1 -> START.
REQ-010 START: on tick OVERSAMPLE/2 sample rx; 1 -> IDLE (glitch rejected, no error); 0 -> DATA, bit count 0.
REQ-011 DATA: sample every OVERSAMPLE ticks, shift in LSB first; after the 8th sample -> STOP.
REQ-012 STOP: sample after OVERSAMPLE ticks; 1 -> push byte, go IDLE; 0 -> pulse err_framing, discard byte, go WAIT_HIGH.
REQ-013 WAIT_HIGH: remain until synchronised rx=1, then IDLE (break conditions produce exactly one err_framing).
REQ-014 A pushed byte SHALL appear on out_data/out_valid on the clk edge after the stop-bit sample when the FIFO was empty.
REQ-015 Pop SHALL occur on any cycle with out_valid=1 and out_ready=1; out_data then shows the next entry or holds stale data with out_valid=0.
REQ-016 Push while full with no pop SHALL drop the new byte, keep FIFO contents, pulse err_overrun for one cycle.
REQ-017 Push and pop in the same cycle while full SHALL accept the push; no overrun; fifo_level unchanged.
REQ-018 Push and pop in the same cycle while non-full SHALL leave fifo_level unchanged.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range 0..FIFO_DEPTH.
REQ-020 en=0 SHALL force state to IDLE within one cycle, abandoning any partial frame without push or error; FIFO contents and pop remain operational.
REQ-021 err_framing and err_overrun SHALL never assert for more than one consecutive cycle per event.

Reset
REQ-022 On rst_n=0, asynchronously: state IDLE, synchroniser flops 1, prescaler/tick/bit counters 0, FIFO empty, out_valid 0, fifo_level 0, out_data 0, err_framing 0, err_overrun 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; after release the first falling edge starts a fresh frame.

Verification
REQ-024 clkdiv=1, OVERSAMPLE=16, en=1, frame 0xA5 with valid stop -> out_data=0xA5, out_valid=1, fifo_level=1, no error pulses.
REQ-025 rx low for 3 ticks then high -> returns to IDLE, no push, no err_framing; a following 0x3C frame is received as 0x3C.
REQ-026 frame 0x55 with stop bit 0, rx held low 40 bit-times -> exactly one err_framing pulse, fifo_level=0; next 0x12 frame after rx high received correctly.
REQ-027 out_ready=0, five frames 0x01..0x05 -> fifo_level=4, one err_overrun on the fifth; draining yields 0x01,0x02,0x03,0x04.
REQ-028 FIFO full, out_ready=1 on the cycle the fifth byte is pushed -> no err_overrun, fifo_level stays 4, 0x05 read last.
REQ-029 en or rst_n deasserted during bit 4 of a frame -> no push, no error, idle state; next complete frame 0x7E received as 0x7E.
